vnp4_axil_cmd_master: RTL
=========================

# vnp4_axil_cmd_master

Synthesizable AXI4-lite master that turns a valid/ready command stream (single-beat reads/writes) into AXI4-lite transactions toward the VNP4 control interface (`vnp4_avmm_to_axi4lite` path). It replaces DPI-driven, one-at-a-time table programming with an RTL engine that supports:

- parametrised address/data widths;
- up to `MAX_OUTSTANDING` in-flight transactions;
- in-order response return, with response checking and saturating error counters;
- a per-transaction timeout with a sticky fault.

## Interface

**Parameters**

- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 32, AXI data width; only 32 or 64 are legal.
- `MAX_OUTSTANDING`, 4, maximum issued-but-unanswered transactions; legal range 1..16.
- `TIMEOUT_CYCLES`, 50, cycles without progress before a timeout is declared; must be ≥ 2.
- `CNT_WIDTH`, 16, width of each statistics counter.

**Ports** (single clock domain; reset is asynchronous, active-low)

- `axi_aclk`  in  1  clock.
- `axi_aresetn`  in  1  asynchronous active-low reset.
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  `ADDR_WIDTH`  byte address.
- `cmd_wdata`  in  `DATA_WIDTH`  write data.
- `cmd_wstrb`  in  `DATA_WIDTH/8`  write byte strobes.
- `rsp_valid` / `rsp_ready`  out / in  1  response handshake.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_rdata`  out  `DATA_WIDTH`  read data; 0 for writes.
- `rsp_resp`  out  2  AXI response code.
- `rsp_timeout`  out  1  response was synthesized by a timeout.
- `m_axi_aw*`, `m_axi_w*`, `m_axi_b*`, `m_axi_ar*`, `m_axi_r*`  standard AXI4-lite master channels, widths per parameters.
- `wr_ok_cnt`, `wr_err_cnt`, `rd_ok_cnt`, `rd_err_cnt`, `timeout_cnt`  out  `CNT_WIDTH`  saturating statistics.
- `fault`  out  1  sticky; cleared only by reset.

## Operation

**Issue FSM states:** `IDLE`, `WR_ISSUE`, `RD_ISSUE`, `FAULT`.

**Command acceptance**

- `cmd_ready` = (state == `IDLE`) && !`fault` && `outstanding` < `MAX_OUTSTANDING` && (`outstanding` == 0 || `dir` == `cmd_write`).
- A direction change therefore drains all outstanding transactions first. This guarantees in-order responses across the independent B and R channels.

**`IDLE` transitions** (on command accept)

- Write: register addr/data/strb, set `dir`=1, go to `WR_ISSUE`.
- Read: set `dir`=0, go to `RD_ISSUE`.

**`WR_ISSUE`**

- `awvalid` and `wvalid` are both asserted together.
- Each valid drops independently on its own handshake; valids never drop before ready.
- Return to `IDLE` when both AW and W have completed; `outstanding` increments.

**`RD_ISSUE`**

- `arvalid` is asserted until `arready`; then return to `IDLE` and `outstanding` increments.

**Response path**

- `bready` = `rready` = !`rsp_valid` || `rsp_ready`.
- On a B or R handshake:
  - Load the response register: `rsp_write`, `rsp_rdata`, `rsp_resp`, `rsp_timeout`=0.
  - Decrement `outstanding`.
  - Increment the matching ok counter if `resp` == OKAY, otherwise the matching err counter.
- Counters saturate at all-ones.

**Simultaneous events:** issue-completion and response-handshake in the same cycle leave `outstanding` unchanged.

**Timeout**

- The counter runs while state is `WR_ISSUE`/`RD_ISSUE` or `outstanding` > 0.
- It clears on any issue-channel handshake or B/R handshake, and also when the block goes idle.
- On reaching `TIMEOUT_CYCLES`:
  - emit a response with `rsp_timeout`=1, `rsp_resp`=2'b10, `rsp_write`=`dir`;
  - increment `timeout_cnt`;
  - set `fault`;
  - enter `FAULT`.
- If the response register is occupied at that point, the timeout response waits until it drains.

**`FAULT`**

- `cmd_ready`=0.
- aw/w/arvalid are forced to 0. This is an accepted protocol violation: the slave is considered dead.
- `bready`/`rready` are held at 1; late responses are dropped and not counted.
- `FAULT` is exited only by reset.

**Reset** (asynchronous, any time including mid-transaction)

- All valids = 0, `bready`/`rready` = 0.
- `rsp_valid` = 0; all `rsp_*` outputs = 0.
- All counters = 0, `fault` = 0, `outstanding` = 0, state = `IDLE`.
- `m_axi_wstrb` = 0; address/data outputs = 0.

## Timing

- **Command to AXI:** a command accepted at edge N presents aw/w/arvalid from edge N+1.
- **AXI to response:** a B/R handshake at edge M presents `rsp_valid` from edge M+1.
- **Throughput:** one command per 2 cycles minimum (accept + issue handshake) with a zero-wait slave.
- **Timeout:** fires on the `TIMEOUT_CYCLES`-th consecutive cycle without progress; `rsp_valid` appears the following cycle.
- **Response handshake:** `rsp_valid` holds until `rsp_ready`; the response register is a single entry, so backpressure on `rsp_ready` stalls B/R acceptance.

## Structure

- **Package `vnp4_axil_pkg`:** response codes OKAY/EXOKAY/SLVERR/DECERR, issue-state enum, and the `MAX_OUTSTANDING` legal-range check.
- **Sub-module `vnp4_axil_rsp_reg`:** the single-entry response register with valid/ready and load-from-B/R/timeout muxing.
- **Top level:** issue FSM, outstanding counter, timeout counter, statistics.

## Test plan

- **Zero-wait slave, write then read:** write 0xDEADBEEF to 0x100, then read 0x100 → two responses in order; `rsp_rdata`=0xDEADBEEF; `wr_ok_cnt`=1, `rd_ok_cnt`=1.
- **AW/W skew:** `awready` 5 cycles after `wready` → `wvalid` drops first, `awvalid` stays high through cycle 5, `outstanding`=1 only after both.
- **Outstanding limit:** 6 back-to-back reads with `MAX_OUTSTANDING`=4 and R delayed 20 cycles → `cmd_ready` low after 4; 6 responses in address order.
- **Direction switch:** 2 writes, then a read, with B delayed 10 cycles → read is not accepted until both B handshakes complete.
- **Error and timeout:** `bresp`=2'b10 → `wr_err_cnt`=1. Then a read never answered with `TIMEOUT_CYCLES`=50 → `rsp_timeout`=1, `rsp_resp`=2'b10, `fault`=1, `cmd_ready`=0. A later `rvalid` is dropped. After reset, all counters are 0.

Source files
------------

// File: rtl/vnp4_axil_pkg.sv
// Shared definitions for the VNP4 AXI4-lite command master: response codes,
// issue-state encoding and parameter legality helpers.
package vnp4_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MAX_OUTSTANDING_MIN = 1;
    localparam int MAX_OUTSTANDING_MAX = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2,
        FAULT    = 2'd3
    } issue_state_e;

    function automatic bit max_outstanding_legal(input int n);
        return (n >= MAX_OUTSTANDING_MIN) && (n <= MAX_OUTSTANDING_MAX);
    endfunction

endpackage

// File: rtl/vnp4_axil_rsp_reg.sv
// Single-entry response register fed from the B channel, the R channel or a
// synthesized timeout; holds until the consumer takes it.
module vnp4_axil_rsp_reg
    import vnp4_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  ld_b,
    input  logic                  ld_r,
    input  logic                  ld_to,
    input  logic [1:0]            b_resp,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  to_write,
    input  logic                  rsp_ready,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout
);

    logic                  valid_r;
    logic                  write_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            resp_r;
    logic                  timeout_r;

    // Load priority B > R > timeout; the caller only loads when the slot is free.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            valid_r   <= 1'b0;
            write_r   <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            resp_r    <= 2'b00;
            timeout_r <= 1'b0;
        end else if (ld_b) begin
            valid_r   <= 1'b1;
            write_r   <= 1'b1;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            resp_r    <= b_resp;
            timeout_r <= 1'b0;
        end else if (ld_r) begin
            valid_r   <= 1'b1;
            write_r   <= 1'b0;
            rdata_r   <= r_data;
            resp_r    <= r_resp;
            timeout_r <= 1'b0;
        end else if (ld_to) begin
            valid_r   <= 1'b1;
            write_r   <= to_write;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            resp_r    <= RESP_SLVERR;
            timeout_r <= 1'b1;
        end else if (rsp_ready) begin
            valid_r   <= 1'b0;
        end
    end

    assign rsp_valid   = valid_r;
    assign rsp_write   = write_r;
    assign rsp_rdata   = rdata_r;
    assign rsp_resp    = resp_r;
    assign rsp_timeout = timeout_r;

endmodule

// File: rtl/vnp4_axil_cmd_master.sv
// AXI4-lite master turning a single-beat command stream into in-order AXI
// transactions, with outstanding tracking, statistics and a sticky timeout fault.
module vnp4_axil_cmd_master
    import vnp4_axil_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 50,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [CNT_WIDTH-1:0]    wr_ok_cnt,
    output logic [CNT_WIDTH-1:0]    wr_err_cnt,
    output logic [CNT_WIDTH-1:0]    rd_ok_cnt,
    output logic [CNT_WIDTH-1:0]    rd_err_cnt,
    output logic [CNT_WIDTH-1:0]    timeout_cnt,
    output logic                    fault
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] ONE_C     = OW'(1'b1);
    localparam logic [TW-1:0] TO_LAST_C = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TONE_C    = TW'(1'b1);

    if (!max_outstanding_legal(MAX_OUTSTANDING) || !(DATA_WIDTH == 32 || DATA_WIDTH == 64)
        || TIMEOUT_CYCLES < 2) begin : g_param_err
        $error("vnp4_axil_cmd_master: illegal parameter set");
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1'b1);
    endfunction

    issue_state_e            state_r, state_nx_s;
    logic                    ready_en_r;
    logic                    dir_r;
    logic                    fault_r;
    logic                    to_pend_r;
    logic [OW-1:0]           outstanding_r;
    logic [TW-1:0]           timer_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH/8-1:0] wstrb_r;
    logic                    awvalid_r, wvalid_r, arvalid_r;
    logic [CNT_WIDTH-1:0]    wr_ok_r, wr_err_r, rd_ok_r, rd_err_r, to_cnt_r;

    logic live_s, rsp_free_s, cmd_ready_s, accept_s, resp_ready_s;
    logic aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s, progress_s;
    logic ld_b_s, ld_r_s, ld_to_s, rsp_evt_s, issue_done_s;
    logic timer_active_s, timeout_s;

    assign live_s         = (state_r != FAULT);
    assign rsp_free_s     = !rsp_valid || rsp_ready;
    assign aw_hs_s        = awvalid_r && m_axi_awready;
    assign w_hs_s         = wvalid_r && m_axi_wready;
    assign ar_hs_s        = arvalid_r && m_axi_arready;
    // Once faulted the slave is presumed dead: swallow anything it still sends.
    assign resp_ready_s   = ready_en_r && (!live_s || rsp_free_s);
    assign b_hs_s         = m_axi_bvalid && resp_ready_s;
    assign r_hs_s         = m_axi_rvalid && resp_ready_s;
    assign progress_s     = aw_hs_s || w_hs_s || ar_hs_s || b_hs_s || r_hs_s;
    assign ld_b_s         = b_hs_s && live_s;
    assign ld_r_s         = r_hs_s && live_s && !ld_b_s;
    assign rsp_evt_s      = ld_b_s || ld_r_s;
    assign timer_active_s = (state_r == WR_ISSUE) || (state_r == RD_ISSUE) || (outstanding_r != {OW{1'b0}});
    assign timeout_s      = live_s && timer_active_s && !progress_s && (timer_r == TO_LAST_C);
    assign ld_to_s        = (timeout_s || to_pend_r) && rsp_free_s;
    // Mixing directions only after a full drain keeps B and R answers in order.
    assign cmd_ready_s    = ready_en_r && (state_r == IDLE) && !fault_r && !timeout_s
                            && (outstanding_r < MAX_OUT_C)
                            && ((outstanding_r == {OW{1'b0}}) || (dir_r == cmd_write));
    assign accept_s       = cmd_valid && cmd_ready_s;

    // Issue FSM next-state and issue-completion strobe.
    always_comb begin
        state_nx_s   = state_r;
        issue_done_s = 1'b0;
        if (timeout_s) begin
            state_nx_s = FAULT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nx_s = cmd_write ? WR_ISSUE : RD_ISSUE;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                WR_ISSUE: begin
                    if (!(awvalid_r && !m_axi_awready) && !(wvalid_r && !m_axi_wready)) begin
                        state_nx_s   = IDLE;
                        issue_done_s = 1'b1;
                    end else begin
                        state_nx_s = WR_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (ar_hs_s) begin
                        state_nx_s   = IDLE;
                        issue_done_s = 1'b1;
                    end else begin
                        state_nx_s = RD_ISSUE;
                    end
                end
                FAULT:   state_nx_s = FAULT;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State, issue channel registers, outstanding and timeout tracking.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r       <= IDLE;
            ready_en_r    <= 1'b0;
            dir_r         <= 1'b0;
            fault_r       <= 1'b0;
            to_pend_r     <= 1'b0;
            outstanding_r <= {OW{1'b0}};
            timer_r       <= {TW{1'b0}};
            addr_r        <= {ADDR_WIDTH{1'b0}};
            wdata_r       <= {DATA_WIDTH{1'b0}};
            wstrb_r       <= {(DATA_WIDTH/8){1'b0}};
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            arvalid_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ready_en_r <= 1'b1;
            to_pend_r  <= (timeout_s || to_pend_r) && !rsp_free_s;
            timer_r    <= (live_s && timer_active_s && !progress_s && timer_r != TO_LAST_C)
                          ? timer_r + TONE_C : {TW{1'b0}};
            if (timeout_s) begin
                fault_r   <= 1'b1;
                awvalid_r <= 1'b0;
                wvalid_r  <= 1'b0;
                arvalid_r <= 1'b0;
            end else if (accept_s) begin
                dir_r  <= cmd_write;
                addr_r <= cmd_addr;
                if (cmd_write) begin
                    wdata_r   <= cmd_wdata;
                    wstrb_r   <= cmd_wstrb;
                    awvalid_r <= 1'b1;
                    wvalid_r  <= 1'b1;
                end else begin
                    arvalid_r <= 1'b1;
                end
            end else begin
                if (aw_hs_s) awvalid_r <= 1'b0;
                if (w_hs_s)  wvalid_r  <= 1'b0;
                if (ar_hs_s) arvalid_r <= 1'b0;
            end
            case ({issue_done_s, rsp_evt_s})
                2'b10:   outstanding_r <= outstanding_r + ONE_C;
                2'b01:   outstanding_r <= outstanding_r - ONE_C;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Saturating statistics.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ok_r  <= {CNT_WIDTH{1'b0}};
            wr_err_r <= {CNT_WIDTH{1'b0}};
            rd_ok_r  <= {CNT_WIDTH{1'b0}};
            rd_err_r <= {CNT_WIDTH{1'b0}};
            to_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (ld_b_s) begin
                if (m_axi_bresp == RESP_OKAY) wr_ok_r <= sat_inc(wr_ok_r);
                else                          wr_err_r <= sat_inc(wr_err_r);
            end
            if (ld_r_s) begin
                if (m_axi_rresp == RESP_OKAY) rd_ok_r <= sat_inc(rd_ok_r);
                else                          rd_err_r <= sat_inc(rd_err_r);
            end
            if (timeout_s) to_cnt_r <= sat_inc(to_cnt_r);
        end
    end

    vnp4_axil_rsp_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_reg (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .ld_b        (ld_b_s),
        .ld_r        (ld_r_s),
        .ld_to       (ld_to_s),
        .b_resp      (m_axi_bresp),
        .r_data      (m_axi_rdata),
        .r_resp      (m_axi_rresp),
        .to_write    (dir_r),
        .rsp_ready   (rsp_ready),
        .rsp_valid   (rsp_valid),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout)
    );

    assign cmd_ready     = cmd_ready_s;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = resp_ready_s;
    assign m_axi_araddr  = addr_r;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = resp_ready_s;
    assign wr_ok_cnt     = wr_ok_r;
    assign wr_err_cnt    = wr_err_r;
    assign rd_ok_cnt     = rd_ok_r;
    assign rd_err_cnt    = rd_err_r;
    assign timeout_cnt   = to_cnt_r;
    assign fault         = fault_r;

endmodule
